// File: rtl/ysyx_25040111_idu_pkg.sv
// Shared decode constants, control-bundle type and the ALU field helper for the IDU.
package ysyx_25040111_idu_pkg;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [6:0]  F7_BASE     = 7'b0000000;
    localparam logic [6:0]  F7_ALT      = 7'b0100000;
    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

    localparam logic [2:0] ALU_PASS  = 3'b000;
    localparam logic [2:0] ALU_ADD   = 3'b001;
    localparam logic [2:0] ALU_LOGIC = 3'b010;
    localparam logic [2:0] ALU_XOR   = 3'b011;
    localparam logic [2:0] ALU_SLL   = 3'b100;
    localparam logic [2:0] ALU_SR    = 3'b101;
    localparam logic [2:0] ALU_LT    = 3'b110;
    localparam logic [2:0] ALU_EQ    = 3'b111;

    localparam logic [1:0] SRC1_RS1  = 2'b00;
    localparam logic [1:0] SRC1_PC   = 2'b01;
    localparam logic [1:0] SRC1_ZERO = 2'b10;
    localparam logic       SRC2_RS2  = 1'b0;
    localparam logic       SRC2_IMM  = 1'b1;

    localparam logic [1:0] MEM_B = 2'd0;
    localparam logic [1:0] MEM_H = 2'd1;
    localparam logic [1:0] MEM_W = 2'd2;

    typedef struct packed {
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rd_wen;
        logic [1:0]  src1_sel;
        logic        src2_sel;
        logic [2:0]  alu_opt;
        logic        alu_ext;
        logic        alu_sign;
        logic        alu_negate;
        logic        alu_snpc;
        logic        branch;
        logic        jal;
        logic        jalr;
        logic        mem_ren;
        logic        mem_wen;
        logic [1:0]  mem_size;
        logic        mem_uns;
        logic        ecall;
        logic        ebreak;
        logic        illegal;
    } ctrl_t;

    // {opt, ext, sign} for the integer ops; alt selects SUB/SRA/SRAI variants
    function automatic logic [4:0] alu_fields(input logic [2:0] funct3, input logic alt);
        logic [4:0] f;
        case (funct3)
            3'b000:  f = {ALU_ADD,   alt,  1'b0};
            3'b001:  f = {ALU_SLL,   1'b0, 1'b0};
            3'b010:  f = {ALU_LT,    1'b1, 1'b1};
            3'b011:  f = {ALU_LT,    1'b1, 1'b0};
            3'b100:  f = {ALU_XOR,   1'b0, 1'b0};
            3'b101:  f = {ALU_SR,    1'b0, alt};
            3'b110:  f = {ALU_LOGIC, 1'b1, 1'b0};
            3'b111:  f = {ALU_LOGIC, 1'b0, 1'b0};
            default: f = {ALU_PASS,  1'b0, 1'b0};
        endcase
        return f;
    endfunction

endpackage

// File: rtl/ysyx_25040111_idu_immgen.sv
// Combinational immediate generator: selects the RV32I immediate format from the opcode.
module ysyx_25040111_immgen
    import ysyx_25040111_idu_pkg::*;
(
    input  logic [31:0] inst,
    output logic [31:0] imm
);

    // format select; R-type, FENCE and SYSTEM carry no immediate
    always_comb begin
        imm = 32'd0;
        case (inst[6:0])
            OPC_OP_IMM, OPC_LOAD, OPC_JALR:
                imm = {{20{inst[31]}}, inst[31:20]};
            OPC_STORE:
                imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            OPC_BRANCH:
                imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm = {inst[31:12], 12'd0};
            OPC_JAL:
                imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default:
                imm = 32'd0;
        endcase
    end

endmodule

// File: rtl/ysyx_25040111_idu.sv
// RV32I decode stage with a one-entry valid/ready output register and flush.
// Optional: define YSYX_25040111_RV32E_EN to flag register indices >= 16 as illegal.
module ysyx_25040111_idu
    import ysyx_25040111_idu_pkg::*;
#(
    parameter int          XLEN   = 32,
    parameter logic [31:0] RST_PC = 32'h8000_0000
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_imm,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic            out_rd_wen,
    output logic [1:0]      out_src1_sel,
    output logic            out_src2_sel,
    output logic [2:0]      out_alu_opt,
    output logic            out_alu_ext,
    output logic            out_alu_sign,
    output logic            out_alu_negate,
    output logic            out_alu_snpc,
    output logic            out_branch,
    output logic            out_jal,
    output logic            out_jalr,
    output logic            out_mem_ren,
    output logic            out_mem_wen,
    output logic [1:0]      out_mem_size,
    output logic            out_mem_uns,
    output logic            out_ecall,
    output logic            out_ebreak,
    output logic            out_illegal
);

    logic [6:0]      opcode_s;
    logic [2:0]      funct3_s;
    logic [6:0]      funct7_s;
    logic [31:0]     imm_s;
    ctrl_t           dec_s;
    ctrl_t           ctrl_s;
    logic            legal_s;
    logic            use_rs1_s;
    logic            use_rs2_s;
    logic            use_rd_s;
    logic            rv32e_bad_s;
    logic            fire_s;
    logic            valid_r;
    ctrl_t           ctrl_r;
    logic [XLEN-1:0] pc_r;

    assign opcode_s = in_inst[6:0];
    assign funct3_s = in_inst[14:12];
    assign funct7_s = in_inst[31:25];

    ysyx_25040111_immgen u_immgen (
        .inst (in_inst),
        .imm  (imm_s)
    );

    // opcode/funct decode into the control bundle plus legality and register usage
    always_comb begin
        dec_s     = '0;
        legal_s   = 1'b1;
        use_rs1_s = 1'b0;
        use_rs2_s = 1'b0;
        use_rd_s  = 1'b0;
        case (opcode_s)
            OPC_LUI, OPC_AUIPC: begin
                dec_s.src1_sel = (opcode_s == OPC_LUI) ? SRC1_ZERO : SRC1_PC;
                dec_s.src2_sel = SRC2_IMM;
                dec_s.alu_opt  = ALU_ADD;
                use_rd_s       = 1'b1;
            end
            OPC_JAL, OPC_JALR: begin
                dec_s.src1_sel = SRC1_PC;
                dec_s.src2_sel = SRC2_IMM;
                dec_s.alu_opt  = ALU_ADD;
                dec_s.alu_snpc = 1'b1;
                dec_s.jal      = (opcode_s == OPC_JAL);
                dec_s.jalr     = (opcode_s == OPC_JALR);
                use_rs1_s      = (opcode_s == OPC_JALR);
                use_rd_s       = 1'b1;
                legal_s        = (opcode_s == OPC_JAL) || (funct3_s == 3'b000);
            end
            OPC_BRANCH: begin
                dec_s.branch  = 1'b1;
                dec_s.alu_ext = 1'b1;
                use_rs1_s     = 1'b1;
                use_rs2_s     = 1'b1;
                // funct3[0] inverts the sense (BNE/BGE/BGEU), funct3[1] picks unsigned lt
                case (funct3_s)
                    3'b000, 3'b001: begin
                        dec_s.alu_opt    = ALU_EQ;
                        dec_s.alu_negate = funct3_s[0];
                    end
                    3'b100, 3'b101, 3'b110, 3'b111: begin
                        dec_s.alu_opt    = ALU_LT;
                        dec_s.alu_sign   = ~funct3_s[1];
                        dec_s.alu_negate = funct3_s[0];
                    end
                    default: legal_s = 1'b0;
                endcase
            end
            OPC_LOAD, OPC_STORE: begin
                dec_s.src2_sel = SRC2_IMM;
                dec_s.alu_opt  = ALU_ADD;
                dec_s.mem_ren  = (opcode_s == OPC_LOAD);
                dec_s.mem_wen  = (opcode_s == OPC_STORE);
                dec_s.mem_size = funct3_s[1:0];
                dec_s.mem_uns  = funct3_s[2];
                use_rs1_s      = 1'b1;
                use_rs2_s      = (opcode_s == OPC_STORE);
                use_rd_s       = (opcode_s == OPC_LOAD);
                if (funct3_s[1:0] == 2'b11) begin
                    legal_s = 1'b0;
                end else if (funct3_s[2]) begin
                    legal_s = (opcode_s == OPC_LOAD) && (funct3_s[1:0] != MEM_W);
                end else begin
                    legal_s = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                dec_s.src2_sel = SRC2_IMM;
                {dec_s.alu_opt, dec_s.alu_ext, dec_s.alu_sign} =
                    alu_fields(funct3_s, (funct3_s == 3'b101) && funct7_s[5]);
                use_rs1_s = 1'b1;
                use_rd_s  = 1'b1;
                if (funct3_s == 3'b001) begin
                    legal_s = (funct7_s == F7_BASE);
                end else if (funct3_s == 3'b101) begin
                    legal_s = (funct7_s == F7_BASE) || (funct7_s == F7_ALT);
                end else begin
                    legal_s = 1'b1;
                end
            end
            OPC_OP: begin
                dec_s.src2_sel = SRC2_RS2;
                {dec_s.alu_opt, dec_s.alu_ext, dec_s.alu_sign} = alu_fields(funct3_s, funct7_s[5]);
                use_rs1_s = 1'b1;
                use_rs2_s = 1'b1;
                use_rd_s  = 1'b1;
                legal_s   = (funct7_s == F7_BASE) ||
                            ((funct7_s == F7_ALT) && ((funct3_s == 3'b000) || (funct3_s == 3'b101)));
            end
            OPC_MISC_MEM: legal_s = (funct3_s == 3'b000);
            OPC_SYSTEM: begin
                dec_s.ecall  = (in_inst == INST_ECALL);
                dec_s.ebreak = (in_inst == INST_EBREAK);
                legal_s      = (in_inst == INST_ECALL) || (in_inst == INST_EBREAK);
            end
            default: legal_s = 1'b0;
        endcase
        dec_s.imm    = imm_s;
        dec_s.rs1    = use_rs1_s ? in_inst[19:15] : 5'd0;
        dec_s.rs2    = use_rs2_s ? in_inst[24:20] : 5'd0;
        dec_s.rd     = use_rd_s  ? in_inst[11:7]  : 5'd0;
        dec_s.rd_wen = use_rd_s && (in_inst[11:7] != 5'd0);
    end

`ifdef YSYX_25040111_RV32E_EN
    assign rv32e_bad_s = (use_rs1_s && in_inst[19]) || (use_rs2_s && in_inst[24]) ||
                         (use_rd_s && in_inst[11]);
`else
    assign rv32e_bad_s = 1'b0;
`endif

    // illegal encodings carry only the trap flag
    always_comb begin
        ctrl_s = '0;
        if (legal_s && !rv32e_bad_s) begin
            ctrl_s = dec_s;
        end else begin
            ctrl_s.illegal = 1'b1;
        end
    end

    assign in_ready = !valid_r || out_ready;
    assign fire_s   = in_valid && in_ready;

    // pipeline register: reset over flush over transfer over drain
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_r <= 1'b0;
            ctrl_r  <= '0;
            pc_r    <= RST_PC[XLEN-1:0];
        end else if (flush) begin
            valid_r <= 1'b0;
        end else if (fire_s) begin
            valid_r <= 1'b1;
            ctrl_r  <= ctrl_s;
            pc_r    <= in_pc;
        end else if (out_ready) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign out_valid      = valid_r;
    assign out_pc         = pc_r;
    assign out_imm        = ctrl_r.imm;
    assign out_rs1        = ctrl_r.rs1;
    assign out_rs2        = ctrl_r.rs2;
    assign out_rd         = ctrl_r.rd;
    assign out_rd_wen     = ctrl_r.rd_wen;
    assign out_src1_sel   = ctrl_r.src1_sel;
    assign out_src2_sel   = ctrl_r.src2_sel;
    assign out_alu_opt    = ctrl_r.alu_opt;
    assign out_alu_ext    = ctrl_r.alu_ext;
    assign out_alu_sign   = ctrl_r.alu_sign;
    assign out_alu_negate = ctrl_r.alu_negate;
    assign out_alu_snpc   = ctrl_r.alu_snpc;
    assign out_branch     = ctrl_r.branch;
    assign out_jal        = ctrl_r.jal;
    assign out_jalr       = ctrl_r.jalr;
    assign out_mem_ren    = ctrl_r.mem_ren;
    assign out_mem_wen    = ctrl_r.mem_wen;
    assign out_mem_size   = ctrl_r.mem_size;
    assign out_mem_uns    = ctrl_r.mem_uns;
    assign out_ecall      = ctrl_r.ecall;
    assign out_ebreak     = ctrl_r.ebreak;
    assign out_illegal    = ctrl_r.illegal;

endmodule
